axis_packet_downsizer: RTL and testbench

//  Splits each wide AXI4-Stream beat into 1..RATIO narrow words, LSB word first.
//  The word count comes from a run-time configuration and is captured per input beat.

---
 rtl/axis_packet_downsizer_pkg.sv | 15 +
 rtl/axis_skid_buffer.sv | 64 ++++++
 rtl/axis_packet_downsizer.sv | 136 +++++++++++++
 tb/tb_axis_packet_downsizer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/axis_packet_downsizer_pkg.sv
// Shared definitions for the AXI4-Stream packet downsizer.
// Holds the FSM state encoding and the helper that turns the run-time word-count
// configuration into an effective word count.
package axis_packet_downsizer_pkg;

   localparam logic [0:0] ST_IDLE = 1'b0;  // no words left to emit
   localparam logic [0:0] ST_EMIT = 1'b1;  // words of an accepted beat still pending

   // Effective words per beat: 0 or anything above the ratio means "all words".
   function automatic int unsigned word_count(input logic [15:0] cfg, input int unsigned ratio);
      if (cfg == 16'd0 || 32'(cfg) > ratio) return ratio;
      return 32'(cfg);
   endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry registered ready/valid buffer.
// Both in_ready and out_valid come straight from flops, so neither side sees a
// combinational path through this block, and it still moves one word per cycle.
// Ports: clk/rst (async active-high), in_* upstream side, out_* downstream side.
module axis_skid_buffer #(
   parameter int DATA_WIDTH = 33
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready
);
   logic [DATA_WIDTH-1:0] out_data_q, out_data_d, skid_data_q, skid_data_d;
   logic                  out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
   logic                  in_fire;

   // Ready as long as the overflow slot is free.
   assign in_ready  = ~skid_valid_q;
   assign in_fire   = in_valid & in_ready;
   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;

   always_comb begin
      out_data_d   = out_data_q;
      out_valid_d  = out_valid_q;
      skid_data_d  = skid_data_q;
      skid_valid_d = skid_valid_q;
      if (~out_valid_q | out_ready) begin
         // Output register frees up: refill from the skid slot first to keep order.
         if (skid_valid_q) begin
            out_data_d   = skid_data_q;
            out_valid_d  = 1'b1;
            skid_valid_d = 1'b0;
         end else if (in_fire) begin
            out_data_d  = in_data;
            out_valid_d = 1'b1;
         end else begin
            out_valid_d = 1'b0;
         end
      end else if (in_fire) begin
         // Output stalled: park the incoming word.
         skid_data_d  = in_data;
         skid_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_data_q   <= '0;
         out_valid_q  <= 1'b0;
         skid_data_q  <= '0;
         skid_valid_q <= 1'b0;
      end else begin
         out_data_q   <= out_data_d;
         out_valid_q  <= out_valid_d;
         skid_data_q  <= skid_data_d;
         skid_valid_q <= skid_valid_d;
      end
   end
endmodule

// File: rtl/axis_packet_downsizer.sv
// Splits each wide AXI4-Stream beat into 1..RATIO narrow words, LSB word first.
// The word count is taken from cfg_data at input acceptance; TLAST rides on the
// last emitted word of a beat. Output is registered through a skid buffer.
// Ports: aclk/areset (async active-high), cfg_data (words per beat),
//        s_axis_* wide input, m_axis_* narrow output, sts_data transfer counter.
module axis_packet_downsizer
   import axis_packet_downsizer_pkg::*;
#(
   parameter int S_AXIS_TDATA_WIDTH = 128,
   parameter int M_AXIS_TDATA_WIDTH = 32,
   parameter int STS_WIDTH          = 32
) (
   input  logic                          aclk,
   input  logic                          areset,
   input  logic [15:0]                   cfg_data,
   input  logic [S_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
   input  logic                          s_axis_tvalid,
   input  logic                          s_axis_tlast,
   output logic                          s_axis_tready,
   output logic [M_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
   output logic                          m_axis_tvalid,
   output logic                          m_axis_tlast,
   input  logic                          m_axis_tready,
   output logic [STS_WIDTH-1:0]          sts_data
);
   localparam int          S     = S_AXIS_TDATA_WIDTH;
   localparam int          M     = M_AXIS_TDATA_WIDTH;
   localparam int unsigned RATIO = S / M;
   localparam int          CW    = $clog2(RATIO + 1);
   localparam int          IW    = $clog2(RATIO);

   logic [RATIO-2:0][M-1:0] hold_q, hold_d;   // words 1..RATIO-1 of the current beat
   logic [M-1:0]            w0_q, w0_d;       // word 0 of a beat accepted while emitting
   logic                    pend_q, pend_d;   // w0_q still has to be pushed
   logic                    last_q, last_d;
   logic [CW-1:0]           rem_q, rem_d;
   logic [IW-1:0]           idx_q, idx_d, idx_m1;
   logic [0:0]              state_q, state_d;
   logic [STS_WIDTH-1:0]    sts_q, sts_d;
   logic [CW-1:0]           n_words;
   logic                    buf_in_ready, s_ready, accept, last_push;
   logic                    push_valid, push_last;
   logic [M-1:0]            push_data;
   logic [M:0]              m_word;

   assign n_words       = CW'(word_count(cfg_data, RATIO));
   assign idx_m1        = idx_q - IW'(1);
   // A pending word 0 is the last push only for one-word beats.
   assign last_push     = pend_q ? (rem_q == '0) : (rem_q == CW'(1));
   assign s_ready       = (state_q == ST_IDLE) ? buf_in_ready : (buf_in_ready & last_push);
   assign s_axis_tready = s_ready & ~areset;
   assign accept        = s_axis_tvalid & s_axis_tready;
   assign sts_data      = sts_q;

   always_comb begin
      hold_d     = hold_q;
      w0_d       = w0_q;
      pend_d     = pend_q;
      last_d     = last_q;
      rem_d      = rem_q;
      idx_d      = idx_q;
      push_valid = 1'b0;
      push_data  = s_axis_tdata[M-1:0];
      push_last  = 1'b0;
      if (state_q == ST_IDLE) begin
         // Word 0 goes straight to the buffer in the accept cycle.
         push_valid = accept;
         push_last  = s_axis_tlast & (n_words == CW'(1));
      end else begin
         push_valid = 1'b1;
         if (pend_q) begin
            push_data = w0_q;
            push_last = last_q & (rem_q == '0);
         end else begin
            push_data = hold_q[idx_m1];
            push_last = last_q & (rem_q == CW'(1));
         end
         if (buf_in_ready) begin
            if (pend_q) begin
               pend_d = 1'b0;
            end else begin
               rem_d = rem_q - CW'(1);
               idx_d = (rem_q == CW'(1)) ? '0 : idx_q + IW'(1);
            end
         end
      end
      // A new load overrides the decrement of the finishing beat. Accepted while
      // emitting, word 0 cannot share the buffer slot, so it waits in w0_q.
      if (accept) begin
         hold_d = s_axis_tdata[S-1:M];
         w0_d   = s_axis_tdata[M-1:0];
         pend_d = (state_q == ST_EMIT);
         last_d = s_axis_tlast;
         rem_d  = n_words - CW'(1);
         idx_d  = IW'(1);
      end
      state_d = (rem_d != '0 || pend_d) ? ST_EMIT : ST_IDLE;
      sts_d   = sts_q + STS_WIDTH'(m_axis_tvalid & m_axis_tready);
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         hold_q  <= '0;
         w0_q    <= '0;
         pend_q  <= 1'b0;
         last_q  <= 1'b0;
         rem_q   <= '0;
         idx_q   <= '0;
         state_q <= ST_IDLE;
         sts_q   <= '0;
      end else begin
         hold_q  <= hold_d;
         w0_q    <= w0_d;
         pend_q  <= pend_d;
         last_q  <= last_d;
         rem_q   <= rem_d;
         idx_q   <= idx_d;
         state_q <= state_d;
         sts_q   <= sts_d;
      end
   end

   axis_skid_buffer #(.DATA_WIDTH(M + 1)) u_buf (
      .clk       (aclk),
      .rst       (areset),
      .in_data   ({push_last, push_data}),
      .in_valid  (push_valid),
      .in_ready  (buf_in_ready),
      .out_data  (m_word),
      .out_valid (m_axis_tvalid),
      .out_ready (m_axis_tready)
   );

   assign m_axis_tdata = m_word[M-1:0];
   assign m_axis_tlast = m_word[M];
endmodule

// File: tb/tb_axis_packet_downsizer.sv
// Self-checking bench for axis_packet_downsizer: directed steps plus a randomized
// section, all output words compared against a queue-based reference model.
// The status counter is built 8 bits wide so its wrap is reachable.
module tb_axis_packet_downsizer;
   localparam int S = 128, M = 32, STS = 8, RATIO = 4;

   logic           aclk = 0, areset = 0;
   logic [15:0]    cfg_data = 0;
   logic [S-1:0]   s_tdata = '0;
   logic           s_tvalid = 0, s_tlast = 0, s_tready;
   logic [M-1:0]   m_tdata;
   logic           m_tvalid, m_tlast, m_tready = 0;
   logic [STS-1:0] sts;

   always #5 aclk = ~aclk;

   axis_packet_downsizer #(.S_AXIS_TDATA_WIDTH(S), .M_AXIS_TDATA_WIDTH(M), .STS_WIDTH(STS)) dut (
      .aclk(aclk), .areset(areset), .cfg_data(cfg_data),
      .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast), .s_axis_tready(s_tready),
      .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast), .m_axis_tready(m_tready),
      .sts_data(sts));

   int          pass_cnt = 0, total_cnt = 0;
   logic [M:0]  exp_q[$];
   int unsigned xfer_cnt = 0;
   int          run_len = 0, max_run = 0;
   logic        held_v = 0;
   logic [M:0]  held_w = '0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   // Reference: a beat yields its first N words in LSB order, tlast on word N-1.
   function automatic int words_for(input logic [15:0] c);
      return (c == 16'd0 || int'(c) > RATIO) ? RATIO : int'(c);
   endfunction

   task automatic model_beat(input logic [S-1:0] d, input logic l, input logic [15:0] c);
      int n;
      n = words_for(c);
      for (int k = 0; k < n; k++) exp_q.push_back({l && (k == n - 1), d[k*M +: M]});
   endtask

   // Monitor: handshakes are sampled mid-cycle, between active edges.
   always @(negedge aclk) begin
      if (areset) begin
         exp_q.delete();
         xfer_cnt = 0;
         held_v   = 0;
         run_len  = 0;
      end else begin
         if (held_v) chk("stable", 64'({m_tvalid, m_tlast, m_tdata}), 64'({1'b1, held_w}));
         if (m_tvalid) run_len++; else run_len = 0;
         if (run_len > max_run) max_run = run_len;
         if (m_tvalid && m_tready) begin
            xfer_cnt++;
            if (exp_q.size() == 0) begin
               total_cnt++;
               $error("FAIL extra_word: observed 0x%0h expected no word", {m_tlast, m_tdata});
            end else begin
               chk("word", 64'({m_tlast, m_tdata}), 64'(exp_q.pop_front()));
            end
         end
         held_v = m_tvalid && !m_tready;
         held_w = {m_tlast, m_tdata};
         if (s_tvalid && s_tready) model_beat(s_tdata, s_tlast, cfg_data);
      end
   end

   task automatic do_reset();
      s_tvalid = 0;
      m_tready = 0;
      areset   = 1;
      repeat (3) @(posedge aclk);
      #1 areset = 0;
      @(posedge aclk);
      #1;
   endtask

   task automatic send_beat(input logic [S-1:0] d, input logic l, input logic [15:0] c, output int waited);
      bit ok;
      ok = 0;
      waited = 0;
      s_tdata = d; s_tlast = l; cfg_data = c; s_tvalid = 1;
      for (int i = 0; i < 500; i++) begin
         @(negedge aclk);
         if (s_tready) begin ok = 1; break; end
         waited++;
      end
      @(posedge aclk);
      #1 s_tvalid = 0;
      if (!ok) begin
         total_cnt++;
         $error("FAIL accept_timeout: observed no s_axis_tready expected ready within 500 cycles");
      end
   endtask

   task automatic drain(input string tag);
      m_tready = 1;
      for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge aclk);
      repeat (3) @(posedge aclk);
      #1;
      chk({tag, "_empty"}, 64'(exp_q.size()), 64'd0);
      chk({tag, "_sts"}, 64'(sts), 64'(xfer_cnt % (2 ** STS)));
      chk({tag, "_idle"}, 64'(m_tvalid), 64'd0);
   endtask

   function automatic logic [S-1:0] rnd_beat();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   initial begin
      int   w, beats;
      bit   hs;
      logic [S-1:0] d;

      // Reset state
      #2 areset = 1;
      repeat (2) @(posedge aclk);
      #1;
      chk("rst_mvalid", 64'(m_tvalid), 64'd0);
      chk("rst_mlast", 64'(m_tlast), 64'd0);
      chk("rst_mdata", 64'(m_tdata), 64'd0);
      chk("rst_sts", 64'(sts), 64'd0);
      chk("rst_sready", 64'(s_tready), 64'd0);
      areset = 0;
      @(posedge aclk);
      #1;

      // 1: two full beats back to back, 8 consecutive words
      m_tready = 1;
      max_run  = 0;
      send_beat(128'h33333333_22222222_11111111_00000000, 1'b0, 16'd4, w);
      send_beat(128'h77777777_66666666_55555555_44444444, 1'b0, 16'd4, w);
      chk("t1_accept_wait", 64'(w), 64'd2);
      drain("t1");
      chk("t1_run", 64'(max_run), 64'd8);
      chk("t1_sts8", 64'(sts), 64'd8);

      // 2: two words only, tlast on the second
      send_beat(rnd_beat(), 1'b1, 16'd2, w);
      drain("t2");
      chk("t2_sts10", 64'(sts), 64'd10);

      // 3: out-of-range counts act as the full ratio; one-word beats stream
      send_beat(rnd_beat(), 1'b1, 16'd0, w);
      send_beat(rnd_beat(), 1'b0, 16'd9, w);
      drain("t3a");
      max_run = 0;
      for (int b = 0; b < 6; b++) begin
         send_beat(rnd_beat(), 1'(b == 5), 16'd1, w);
         chk("t3_ready", 64'(w), 64'd0);
      end
      drain("t3b");
      chk("t3_run", 64'(max_run), 64'd6);

      // 4: random valid/ready, cfg changing every cycle
      beats = 0;
      for (int c = 0; c < 40000; c++) begin
         @(negedge aclk);
         hs = s_tvalid && s_tready;
         @(posedge aclk);
         #1;
         if (hs) begin beats++; s_tvalid = 0; end
         if (!s_tvalid && beats < 1000 && $urandom_range(0, 3) != 0) begin
            s_tdata  = rnd_beat();
            s_tlast  = ($urandom_range(0, 2) == 0);
            s_tvalid = 1;
         end
         cfg_data = 16'($urandom_range(0, 6));
         m_tready = 1'($urandom_range(0, 1));
         if (beats == 1000) break;
      end
      if (beats != 1000) begin
         total_cnt++;
         $error("FAIL t4_timeout: observed %0d beats expected 1000", beats);
      end
      drain("t4");

      // 5: reset in the middle of a 4-word beat
      do_reset();
      m_tready = 1;
      send_beat(rnd_beat(), 1'b1, 16'd4, w);
      @(posedge aclk);
      #2 areset = 1;
      #1;
      chk("t5_mvalid", 64'(m_tvalid), 64'd0);
      chk("t5_mdata", 64'(m_tdata), 64'd0);
      chk("t5_mlast", 64'(m_tlast), 64'd0);
      chk("t5_sts", 64'(sts), 64'd0);
      chk("t5_sready", 64'(s_tready), 64'd0);
      @(posedge aclk);
      #1 areset = 0;
      d = rnd_beat();
      send_beat(d, 1'b1, 16'd4, w);
      drain("t5");
      chk("t5_sts4", 64'(sts), 64'd4);

      // 6: status counter wrap
      do_reset();
      m_tready = 1;
      for (int b = 0; b < 63; b++) send_beat(rnd_beat(), 1'b0, 16'd4, w);
      send_beat(rnd_beat(), 1'b1, 16'd3, w);
      drain("t6a");
      chk("t6_sts_max", 64'(sts), 64'd255);
      send_beat(rnd_beat(), 1'b1, 16'd1, w);
      drain("t6b");
      chk("t6_sts_wrap", 64'(sts), 64'd0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: observed simulation still running expected completion");
      $fatal(1, "watchdog expired");
   end
endmodule
